// File: rtl/enigma_pkg.sv
// Shared types, wiring tables, notches and modular helpers for the Enigma core.
// Wheel I/II/III and reflector B tables are stored 0-based (A=0..Z=25).
package enigma_pkg;

  typedef logic [4:0] letter_t;

  localparam letter_t ROT_I [26] = '{
    5'd4,  5'd10, 5'd12, 5'd5,  5'd11, 5'd6,  5'd3,  5'd16, 5'd21, 5'd25, 5'd13, 5'd19, 5'd14,
    5'd22, 5'd24, 5'd7,  5'd23, 5'd20, 5'd18, 5'd15, 5'd0,  5'd8,  5'd1,  5'd17, 5'd2,  5'd9};
  localparam letter_t ROT_I_INV [26] = '{
    5'd20, 5'd22, 5'd24, 5'd6,  5'd0,  5'd3,  5'd5,  5'd15, 5'd21, 5'd25, 5'd1,  5'd4,  5'd2,
    5'd10, 5'd12, 5'd19, 5'd7,  5'd23, 5'd18, 5'd11, 5'd17, 5'd8,  5'd13, 5'd16, 5'd14, 5'd9};
  localparam letter_t ROT_II [26] = '{
    5'd0,  5'd9,  5'd3,  5'd10, 5'd18, 5'd8,  5'd17, 5'd20, 5'd23, 5'd1,  5'd11, 5'd7,  5'd22,
    5'd19, 5'd12, 5'd2,  5'd16, 5'd6,  5'd25, 5'd13, 5'd15, 5'd24, 5'd5,  5'd21, 5'd14, 5'd4};
  localparam letter_t ROT_II_INV [26] = '{
    5'd0,  5'd9,  5'd15, 5'd2,  5'd25, 5'd22, 5'd17, 5'd11, 5'd5,  5'd1,  5'd3,  5'd10, 5'd14,
    5'd19, 5'd24, 5'd20, 5'd16, 5'd6,  5'd4,  5'd13, 5'd7,  5'd23, 5'd12, 5'd8,  5'd21, 5'd18};
  localparam letter_t ROT_III [26] = '{
    5'd1,  5'd3,  5'd5,  5'd7,  5'd9,  5'd11, 5'd2,  5'd15, 5'd17, 5'd19, 5'd23, 5'd21, 5'd25,
    5'd13, 5'd24, 5'd4,  5'd8,  5'd22, 5'd6,  5'd0,  5'd10, 5'd12, 5'd20, 5'd18, 5'd16, 5'd14};
  localparam letter_t ROT_III_INV [26] = '{
    5'd19, 5'd0,  5'd6,  5'd1,  5'd15, 5'd2,  5'd18, 5'd3,  5'd16, 5'd4,  5'd20, 5'd5,  5'd21,
    5'd13, 5'd25, 5'd7,  5'd24, 5'd8,  5'd23, 5'd9,  5'd22, 5'd11, 5'd17, 5'd10, 5'd14, 5'd12};
  localparam letter_t REFL_B [26] = '{
    5'd24, 5'd17, 5'd20, 5'd7,  5'd16, 5'd18, 5'd11, 5'd3,  5'd15, 5'd23, 5'd13, 5'd6,  5'd14,
    5'd10, 5'd12, 5'd8,  5'd4,  5'd1,  5'd5,  5'd25, 5'd2,  5'd22, 5'd21, 5'd9,  5'd0,  5'd19};

  // Turnover positions: the wheel carries its left neighbour when stepping off these.
  localparam letter_t NOTCH_I   = 5'd16;  // Q
  localparam letter_t NOTCH_II  = 5'd4;   // E
  localparam letter_t NOTCH_III = 5'd21;  // V

  typedef enum logic [3:0] {
    S_IDLE, S_STEP, S_R_FWD, S_M_FWD, S_L_FWD, S_REFL,
    S_L_BWD, S_M_BWD, S_R_BWD, S_OUT
  } state_e;

  typedef enum logic [1:0] {ROTOR_I, ROTOR_II, ROTOR_III} rotor_e;
  typedef enum logic {DIR_FWD, DIR_BWD} dir_e;

  // (a + b) mod 26 for operands already in 0..25
  function automatic letter_t add26(letter_t a, letter_t b);
    logic [5:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= 6'd26) s = s - 6'd26;
    return s[4:0];
  endfunction

  // (a - b) mod 26; a negative 6-bit difference has bit 5 set
  function automatic letter_t sub26(letter_t a, letter_t b);
    logic [5:0] d;
    d = {1'b0, a} - {1'b0, b};
    if (d[5]) d = d + 6'd26;
    return d[4:0];
  endfunction

  // Fold an out-of-range 5-bit position (26..31) back into 0..25
  function automatic letter_t wrap26(letter_t v);
    return (v >= 5'd26) ? v - 5'd26 : v;
  endfunction

endpackage

// File: rtl/enigma_rotor_pass.sv
// One combinational pass through a selected wheel at a given position,
// either toward the reflector (forward) or back from it (inverse table).
module enigma_rotor_pass
  import enigma_pkg::*;
(
  input  letter_t c,
  input  letter_t p,
  input  dir_e    dir,
  input  rotor_e  rotor_sel,
  output letter_t c_out
);

  letter_t idx;
  letter_t wired;

  assign idx = add26(c, p);

  // Wheel wiring lookup for the selected wheel and direction
  always_comb begin
    wired = '0;
    case (rotor_sel)
      ROTOR_I:   wired = (dir == DIR_FWD) ? ROT_I[idx]   : ROT_I_INV[idx];
      ROTOR_II:  wired = (dir == DIR_FWD) ? ROT_II[idx]  : ROT_II_INV[idx];
      ROTOR_III: wired = (dir == DIR_FWD) ? ROT_III[idx] : ROT_III_INV[idx];
      default:   wired = '0;
    endcase
  end

  assign c_out = sub26(wired, p);

endmodule

// File: rtl/enigma_core.sv
// Enigma I cipher engine: wheels I-II-III (left to right), reflector B,
// rings at A, no plugboard. One letter walks through the wheels one pass
// per cycle; the finished pair is held for the display stage.
module enigma_core
  import enigma_pkg::*;
(
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        key_valid_in,
  input  logic [4:0]  key_letter_in,
  input  logic        pos_load_in,
  input  logic [14:0] pos_in,
  output logic        ready_out,
  output logic        code_valid_out,
  output logic [4:0]  orig_letter_out,
  output logic [4:0]  code_letter_out,
  output logic [14:0] rotor_pos_out
);

  state_e  state_reg, state_next;
  letter_t pos_l_reg, pos_m_reg, pos_r_reg;
  letter_t c_reg;
  letter_t key_reg;
  letter_t orig_reg, code_reg;
  letter_t load_pos [3];  // 0=right, 1=middle, 2=left
  logic    key_ok;

  letter_t pass_p;
  dir_e    pass_dir;
  rotor_e  pass_sel;
  letter_t pass_out;

  assign key_ok = key_valid_in && (key_letter_in != 5'd0) && (key_letter_in <= 5'd26);

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_load
      assign load_pos[gi] = wrap26(pos_in[gi*5 +: 5]);
    end
  endgenerate

  // State register
  always_ff @(posedge clk_in) begin
    if (rst_in) state_reg <= S_IDLE;
    else        state_reg <= state_next;
  end

  // Next state: a fixed walk through the wheels once a key is taken
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:  if (!pos_load_in && key_ok) state_next = S_STEP;
      S_STEP:  state_next = S_R_FWD;
      S_R_FWD: state_next = S_M_FWD;
      S_M_FWD: state_next = S_L_FWD;
      S_L_FWD: state_next = S_REFL;
      S_REFL:  state_next = S_L_BWD;
      S_L_BWD: state_next = S_M_BWD;
      S_M_BWD: state_next = S_R_BWD;
      S_R_BWD: state_next = S_OUT;
      S_OUT:   state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Handshake outputs decoded from the state
  always_comb begin
    ready_out      = (state_reg == S_IDLE);
    code_valid_out = (state_reg == S_OUT);
  end

  // Steer the shared wheel pass to the wheel/direction of the current state
  always_comb begin
    pass_p   = pos_r_reg;
    pass_dir = DIR_FWD;
    pass_sel = ROTOR_III;
    case (state_reg)
      S_M_FWD: begin pass_p = pos_m_reg; pass_sel = ROTOR_II; end
      S_L_FWD: begin pass_p = pos_l_reg; pass_sel = ROTOR_I; end
      S_L_BWD: begin pass_p = pos_l_reg; pass_sel = ROTOR_I;   pass_dir = DIR_BWD; end
      S_M_BWD: begin pass_p = pos_m_reg; pass_sel = ROTOR_II;  pass_dir = DIR_BWD; end
      S_R_BWD: begin pass_p = pos_r_reg; pass_sel = ROTOR_III; pass_dir = DIR_BWD; end
      default: ;
    endcase
  end

  enigma_rotor_pass u_pass (
    .c         (c_reg),
    .p         (pass_p),
    .dir       (pass_dir),
    .rotor_sel (pass_sel),
    .c_out     (pass_out)
  );

  // Positions, letter datapath and held output letters
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      pos_l_reg <= '0;
      pos_m_reg <= '0;
      pos_r_reg <= '0;
      c_reg     <= '0;
      key_reg   <= '0;
      orig_reg  <= '0;
      code_reg  <= '0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          // A load in the same cycle as a key takes priority; the key is lost
          if (pos_load_in) begin
            pos_r_reg <= load_pos[0];
            pos_m_reg <= load_pos[1];
            pos_l_reg <= load_pos[2];
          end else if (key_ok) begin
            key_reg <= key_letter_in;
            c_reg   <= key_letter_in - 5'd1;
          end
        end
        S_STEP: begin
          // Middle at its notch moves itself and the left wheel (double-step)
          pos_r_reg <= add26(pos_r_reg, 5'd1);
          if (pos_r_reg == NOTCH_III || pos_m_reg == NOTCH_II)
            pos_m_reg <= add26(pos_m_reg, 5'd1);
          if (pos_m_reg == NOTCH_II)
            pos_l_reg <= add26(pos_l_reg, 5'd1);
        end
        S_R_FWD, S_M_FWD, S_L_FWD, S_L_BWD, S_M_BWD: c_reg <= pass_out;
        S_REFL: c_reg <= REFL_B[c_reg];
        S_R_BWD: begin
          c_reg    <= pass_out;
          orig_reg <= key_reg;
          code_reg <= pass_out + 5'd1;
        end
        default: ;
      endcase
    end
  end

  assign orig_letter_out = orig_reg;
  assign code_letter_out = code_reg;
  assign rotor_pos_out   = {pos_l_reg, pos_m_reg, pos_r_reg};

endmodule

// File: tb/tb_enigma_core.sv
// Directed bench for enigma_core: table of hand-computed keypresses plus
// hand-written sequences for busy/invalid keys, load priority and reset.
module tb_enigma_core;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        key_valid = 1'b0;
  logic [4:0]  key_letter = 5'd0;
  logic        pos_load = 1'b0;
  logic [14:0] pos_in = 15'd0;
  logic        ready;
  logic        code_valid;
  logic [4:0]  orig_letter;
  logic [4:0]  code_letter;
  logic [14:0] rotor_pos;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  enigma_core dut (
    .clk_in          (clk),
    .rst_in          (rst),
    .key_valid_in    (key_valid),
    .key_letter_in   (key_letter),
    .pos_load_in     (pos_load),
    .pos_in          (pos_in),
    .ready_out       (ready),
    .code_valid_out  (code_valid),
    .orig_letter_out (orig_letter),
    .code_letter_out (code_letter),
    .rotor_pos_out   (rotor_pos)
  );

  typedef struct {
    bit          do_load;
    logic [14:0] load_pos;
    logic [4:0]  key;
    logic [4:0]  exp_code;
    logic [14:0] exp_pos;
  } vec_t;

  vec_t vecs [11];

  function automatic logic [14:0] p3(int l, int m, int r);
    return {5'(l), 5'(m), 5'(r)};
  endfunction

  task automatic check(string name, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  // Called at a negedge; leaves the bench at a negedge with the load applied
  task automatic do_load(logic [14:0] v);
    pos_load = 1'b1;
    pos_in   = v;
    @(negedge clk);
    pos_load = 1'b0;
  endtask

  // Press one key from IDLE and follow it to the pulse and back to IDLE
  task automatic press(logic [4:0] key, logic [4:0] exp_code, logic [14:0] exp_pos);
    int pulses;
    int pulse_at;
    int ready_bad;
    logic [4:0]  got_orig;
    logic [4:0]  got_code;
    logic [14:0] got_pos;
    pulses = 0; pulse_at = 0; ready_bad = 0;
    got_orig = 5'd0; got_code = 5'd0; got_pos = 15'd0;
    check("ready_before_key", 32'(ready), 32'd1);
    key_valid  = 1'b1;
    key_letter = key;
    @(negedge clk);
    key_valid  = 1'b0;
    key_letter = 5'd0;
    for (int n = 1; n <= 10; n++) begin
      if (code_valid) begin
        pulses++;
        if (pulse_at == 0) pulse_at = n;
        if (n == 9) begin
          got_orig = orig_letter;
          got_code = code_letter;
          got_pos  = rotor_pos;
        end
      end
      if (ready != (n == 10)) ready_bad++;
      if (n < 10) @(negedge clk);
    end
    $display("key %0d -> code %0d pos %0d,%0d,%0d pulse_cycle %0d", key, got_code,
             got_pos[14:10], got_pos[9:5], got_pos[4:0], pulse_at);
    check("pulse_cycle", 32'(pulse_at), 32'd9);
    check("pulse_count", 32'(pulses), 32'd1);
    check("ready_busy_window", 32'(ready_bad), 32'd0);
    check("orig_letter", 32'(got_orig), 32'(key));
    check("code_letter", 32'(got_code), 32'(exp_code));
    check("rotor_pos", 32'(got_pos), 32'(exp_pos));
    check("no_self_encrypt", 32'(got_code != got_orig), 32'd1);
  endtask

  initial begin
    int pulses;
    int pulse_at;
    int ready_bad;
    logic [4:0] bad_letters [3];
    bad_letters = '{5'd0, 5'd27, 5'd31};

    vecs[0]  = '{1'b1, p3(0, 0, 0),    5'd1, 5'd2,  p3(0, 0, 1)};
    vecs[1]  = '{1'b0, p3(0, 0, 0),    5'd1, 5'd4,  p3(0, 0, 2)};
    vecs[2]  = '{1'b0, p3(0, 0, 0),    5'd1, 5'd26, p3(0, 0, 3)};
    vecs[3]  = '{1'b0, p3(0, 0, 0),    5'd1, 5'd7,  p3(0, 0, 4)};
    vecs[4]  = '{1'b0, p3(0, 0, 0),    5'd1, 5'd15, p3(0, 0, 5)};
    vecs[5]  = '{1'b1, p3(0, 3, 20),   5'd1, 5'd5,  p3(0, 3, 21)};
    vecs[6]  = '{1'b0, p3(0, 0, 0),    5'd1, 5'd17, p3(0, 4, 22)};
    vecs[7]  = '{1'b0, p3(0, 0, 0),    5'd1, 5'd9,  p3(1, 5, 23)};
    vecs[8]  = '{1'b1, p3(0, 0, 0),    5'd1, 5'd2,  p3(0, 0, 1)};
    vecs[9]  = '{1'b1, p3(0, 0, 0),    5'd2, 5'd1,  p3(0, 0, 1)};
    vecs[10] = '{1'b1, p3(25, 25, 25), 5'd1, 5'd5,  p3(25, 25, 0)};

    // Reset state
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset_ready", 32'(ready), 32'd1);
    check("reset_valid", 32'(code_valid), 32'd0);
    check("reset_orig", 32'(orig_letter), 32'd0);
    check("reset_code", 32'(code_letter), 32'd0);
    check("reset_pos", 32'(rotor_pos), 32'd0);

    // Table of keypresses
    for (int i = 0; i < 11; i++) begin
      if (vecs[i].do_load) do_load(vecs[i].load_pos);
      press(vecs[i].key, vecs[i].exp_code, vecs[i].exp_pos);
    end

    // Keys and a load while busy are dropped
    do_load(p3(0, 0, 0));
    key_valid = 1'b1; key_letter = 5'd1;
    pulses = 0; pulse_at = 0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (code_valid) begin
        pulses++;
        if (pulse_at == 0) pulse_at = n;
      end
      if (n == 1) key_letter = 5'd5;
      pos_load = (n == 4);
      if (n == 4) pos_in = p3(3, 3, 3);
      if (n == 9) key_valid = 1'b0;
    end
    $display("busy: pulses %0d at cycle %0d code %0d pos %0d", pulses, pulse_at, code_letter, rotor_pos);
    check("busy_pulses", 32'(pulses), 32'd1);
    check("busy_pulse_cycle", 32'(pulse_at), 32'd9);
    check("busy_orig", 32'(orig_letter), 32'd1);
    check("busy_code", 32'(code_letter), 32'd2);
    check("busy_pos", 32'(rotor_pos), 32'(p3(0, 0, 1)));

    // Out-of-range letters are ignored in IDLE
    pulses = 0; ready_bad = 0;
    for (int b = 0; b < 3; b++) begin
      key_valid = 1'b1; key_letter = bad_letters[b];
      repeat (2) begin
        @(negedge clk);
        if (!ready) ready_bad++;
        if (code_valid) pulses++;
      end
      $display("invalid letter %0d: ready %0d", bad_letters[b], ready);
    end
    key_valid = 1'b0; key_letter = 5'd0;
    repeat (12) begin
      @(negedge clk);
      if (code_valid) pulses++;
      if (!ready) ready_bad++;
    end
    check("invalid_ready", 32'(ready_bad), 32'd0);
    check("invalid_pulses", 32'(pulses), 32'd0);
    check("invalid_pos", 32'(rotor_pos), 32'(p3(0, 0, 1)));

    // Load and key together: load wins, key dropped
    pos_load = 1'b1; pos_in = p3(0, 0, 7); key_valid = 1'b1; key_letter = 5'd1;
    @(negedge clk);
    pos_load = 1'b0; key_valid = 1'b0; key_letter = 5'd0;
    check("loadkey_pos", 32'(rotor_pos), 32'(p3(0, 0, 7)));
    check("loadkey_ready", 32'(ready), 32'd1);
    pulses = 0;
    repeat (12) begin
      @(negedge clk);
      if (code_valid) pulses++;
    end
    $display("load+key: pos %0d pulses %0d", rotor_pos, pulses);
    check("loadkey_pulses", 32'(pulses), 32'd0);
    check("loadkey_pos_hold", 32'(rotor_pos), 32'(p3(0, 0, 7)));

    // Load fields above 25 are reduced by 26
    do_load(p3(26, 31, 27));
    $display("load 26,31,27 -> pos %0d,%0d,%0d", rotor_pos[14:10], rotor_pos[9:5], rotor_pos[4:0]);
    check("load_wrap", 32'(rotor_pos), 32'(p3(0, 5, 1)));

    // Reset during M_FWD aborts the encode
    do_load(p3(0, 0, 0));
    key_valid = 1'b1; key_letter = 5'd3;
    @(negedge clk);
    key_valid = 1'b0; key_letter = 5'd0;
    repeat (2) @(negedge clk);
    check("abort_pos_stepped", 32'(rotor_pos), 32'(p3(0, 0, 1)));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_orig", 32'(orig_letter), 32'd0);
    check("abort_code", 32'(code_letter), 32'd0);
    check("abort_pos", 32'(rotor_pos), 32'd0);
    check("abort_ready", 32'(ready), 32'd1);
    pulses = 0;
    repeat (15) begin
      if (code_valid) pulses++;
      @(negedge clk);
    end
    $display("reset at M_FWD: pulses %0d pos %0d", pulses, rotor_pos);
    check("abort_pulses", 32'(pulses), 32'd0);

    // Normal operation resumes after the abort
    press(5'd1, 5'd2, p3(0, 0, 1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
